// File: rtl/sd_fifo_sx.sv
// Single-clock srdy/drdy flop FIFO of arbitrary depth with occupancy count,
// almost-full/empty flags, synchronous flush and optional registered output.
module sd_fifo_sx #(
    parameter int unsigned width    = 8,
    parameter int unsigned depth    = 16,
    parameter int unsigned af_level = depth - 2,
    parameter int unsigned ae_level = 1,
    parameter bit          outreg   = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         c_srdy,
    output logic                         c_drdy,
    input  logic [width-1:0]             c_data,
    output logic                         p_srdy,
    input  logic                         p_drdy,
    output logic [width-1:0]             p_data,
    output logic [$clog2(depth+1)-1:0]   usage,
    output logic                         almost_full,
    output logic                         almost_empty
);

    localparam int unsigned UW = $clog2(depth + 1);
    localparam int unsigned PW = $clog2(depth);
    localparam logic [UW-1:0] DEPTH_U  = UW'(depth);
    localparam logic [UW-1:0] AF_U     = UW'(af_level);
    localparam logic [UW-1:0] AE_U     = UW'(ae_level);
    localparam logic [PW-1:0] PTR_LAST = PW'(depth - 1);

    logic [width-1:0] r_mem [depth];
    logic [PW-1:0]    r_wrptr;
    logic [PW-1:0]    r_rdptr;
    logic [UW-1:0]    r_usage;
    logic             r_pvalid;
    logic             r_af;
    logic             r_ae;

    logic             w_wr;
    logic             w_rd;
    logic             w_rd_adv;
    logic             w_pvalid_nxt;
    logic [UW-1:0]    w_usage_nxt;
    logic [PW-1:0]    w_wrptr_nxt;
    logic [PW-1:0]    w_rdptr_nxt;

    // Handshake qualifiers depend only on registered state, clear and reset.
    assign c_drdy = reset & ~clear & (r_usage < DEPTH_U);
    assign p_srdy = r_pvalid & ~clear;
    assign w_wr   = c_srdy & c_drdy;
    assign w_rd   = p_srdy & p_drdy;

    assign usage        = r_usage;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;

    assign w_wrptr_nxt = (r_wrptr == PTR_LAST) ? '0 : r_wrptr + PW'(1);
    assign w_rdptr_nxt = (r_rdptr == PTR_LAST) ? '0 : r_rdptr + PW'(1);

    // Occupancy counts every held word, including one sitting in the prefetch register.
    always_comb begin
        w_usage_nxt = r_usage;
        if (clear) begin
            w_usage_nxt = '0;
        end else if (w_wr && !w_rd) begin
            w_usage_nxt = r_usage + UW'(1);
        end else if (!w_wr && w_rd) begin
            w_usage_nxt = r_usage - UW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wrptr] <= c_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrptr  <= '0;
            r_rdptr  <= '0;
            r_usage  <= '0;
            r_pvalid <= 1'b0;
            r_af     <= 1'b0;
            r_ae     <= 1'b1;
        end else begin
            r_usage <= w_usage_nxt;
            r_af    <= (w_usage_nxt >= AF_U);
            r_ae    <= (w_usage_nxt <= AE_U);
            if (clear) begin
                r_wrptr  <= '0;
                r_rdptr  <= '0;
                r_pvalid <= 1'b0;
            end else begin
                if (w_wr) begin
                    r_wrptr <= w_wrptr_nxt;
                end
                if (w_rd_adv) begin
                    r_rdptr <= w_rdptr_nxt;
                end
                r_pvalid <= w_pvalid_nxt;
            end
        end
    end

    generate
        if (outreg) begin : g_outreg
            logic             w_stor_nz;
            logic             w_load;
            logic [width-1:0] r_pdata;

            // Prefetch refills whenever it is empty or draining and storage has a word.
            assign w_stor_nz    = (r_usage - UW'(r_pvalid)) != '0;
            assign w_load       = (~r_pvalid | w_rd) & w_stor_nz & ~clear;
            assign w_rd_adv     = w_load;
            assign w_pvalid_nxt = w_load | (r_pvalid & ~w_rd);
            assign p_data       = r_pdata;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_pdata <= '0;
                end else if (w_load) begin
                    r_pdata <= r_mem[r_rdptr];
                end
            end
        end else begin : g_comb
            assign w_rd_adv     = w_rd;
            assign w_pvalid_nxt = (w_usage_nxt != '0);
            assign p_data       = r_mem[r_rdptr];
        end
    endgenerate

endmodule

// File: tb/tb_sd_fifo_sx.sv
// Randomized and directed bench for sd_fifo_sx: instance a (depth 5, comb output)
// and instance b (depth 4, registered output), each checked against a queue model.
module tb_sd_fifo_sx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic       a_clear, a_c_srdy, a_c_drdy, a_p_srdy, a_p_drdy, a_af, a_ae;
    logic [7:0] a_c_data, a_p_data;
    logic [2:0] a_usage;
    logic       b_clear, b_c_srdy, b_c_drdy, b_p_srdy, b_p_drdy, b_af, b_ae;
    logic [7:0] b_c_data, b_p_data;
    logic [2:0] b_usage;

    sd_fifo_sx #(.width(8), .depth(5), .outreg(1'b0)) u_a (
        .clk(clk), .reset(rst_n), .clear(a_clear),
        .c_srdy(a_c_srdy), .c_drdy(a_c_drdy), .c_data(a_c_data),
        .p_srdy(a_p_srdy), .p_drdy(a_p_drdy), .p_data(a_p_data),
        .usage(a_usage), .almost_full(a_af), .almost_empty(a_ae)
    );

    sd_fifo_sx #(.width(8), .depth(4), .outreg(1'b1)) u_b (
        .clk(clk), .reset(rst_n), .clear(b_clear),
        .c_srdy(b_c_srdy), .c_drdy(b_c_drdy), .c_data(b_c_data),
        .p_srdy(b_p_srdy), .p_drdy(b_p_drdy), .p_data(b_p_data),
        .usage(b_usage), .almost_full(b_af), .almost_empty(b_ae)
    );

    // Reference models: a queue of held words; b also tracks whether the head is presented.
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int  preb;
    bit  ma_wr, ma_rd, mb_wr, mb_rd, mb_load;
    int  mb_stor;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qa.delete();
        end else if (a_clear) begin
            qa.delete();
        end else begin
            ma_rd = (qa.size() > 0) && a_p_drdy;
            ma_wr = a_c_srdy && (qa.size() < 5);
            if (ma_rd) void'(qa.pop_front());
            if (ma_wr) qa.push_back(a_c_data);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qb.delete();
            preb = 0;
        end else if (b_clear) begin
            qb.delete();
            preb = 0;
        end else begin
            mb_stor = qb.size() - preb;
            mb_rd   = (preb != 0) && b_p_drdy;
            mb_wr   = b_c_srdy && (qb.size() < 4);
            mb_load = ((preb == 0) || mb_rd) && (mb_stor > 0);
            if (mb_rd) void'(qb.pop_front());
            preb = mb_load ? 1 : (mb_rd ? 0 : preb);
            if (mb_wr) qb.push_back(b_c_data);
        end
    end

    task automatic idle();
        a_clear = 0; a_c_srdy = 0; a_p_drdy = 0; a_c_data = 8'h00;
        b_clear = 0; b_c_srdy = 0; b_p_drdy = 0; b_c_data = 8'h00;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (a_c_drdy !== 1'b0) begin failures++; $display("FAIL reset_c_drdy got=%b exp=0", a_c_drdy); end
        checks++; if (a_p_srdy !== 1'b0 || b_p_srdy !== 1'b0) begin failures++; $display("FAIL reset_p_srdy got=%b/%b exp=0", a_p_srdy, b_p_srdy); end
        checks++; if (a_usage !== 3'd0 || b_usage !== 3'd0) begin failures++; $display("FAIL reset_usage got=%0d/%0d exp=0", a_usage, b_usage); end
        checks++; if (a_af !== 1'b0 || a_ae !== 1'b1) begin failures++; $display("FAIL reset_flags got af=%b ae=%b exp af=0 ae=1", a_af, a_ae); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (a_c_drdy !== 1'b1) begin failures++; $display("FAIL post_reset_c_drdy got=%b exp=1", a_c_drdy); end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a_c_srdy = 1; a_c_data = 8'(8'h11 + i); a_p_drdy = 0;
            #1;
            checks++; if (a_c_drdy !== 1'b1) begin failures++; $display("FAIL fill_c_drdy i=%0d got=%b exp=1", i, a_c_drdy); end
        end
        @(negedge clk);
        a_c_srdy = 0;
        #1;
        checks++; if (a_c_drdy !== 1'b0 || a_usage !== 3'd5 || a_af !== 1'b1) begin
            failures++; $display("FAIL full_state got drdy=%b usage=%0d af=%b exp 0/5/1", a_c_drdy, a_usage, a_af); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a_p_drdy = 1;
            #1;
            checks++; if (a_p_srdy !== 1'b1 || a_p_data !== 8'(8'h11 + i)) begin
                failures++; $display("FAIL drain_data i=%0d got srdy=%b data=%h exp 1/%h", i, a_p_srdy, a_p_data, 8'(8'h11 + i)); end
        end
        @(negedge clk);
        a_p_drdy = 0;
        #1;
        checks++; if (a_usage !== 3'd0 || a_ae !== 1'b1 || a_p_srdy !== 1'b0) begin
            failures++; $display("FAIL drained got usage=%0d ae=%b srdy=%b exp 0/1/0", a_usage, a_ae, a_p_srdy); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            a_c_srdy = 1; a_c_data = 8'(8'h30 + i); a_p_drdy = 0;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a_c_srdy = 1; a_c_data = 8'(8'h32 + i); a_p_drdy = 1;
            #1;
            checks++; if (a_p_data !== 8'(8'h30 + i) || a_usage !== 3'd2) begin
                failures++; $display("FAIL wrap i=%0d got data=%h usage=%0d exp %h/2", i, a_p_data, a_usage, 8'(8'h30 + i)); end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            a_c_srdy = 0; a_p_drdy = 1;
            #1;
            checks++; if (a_p_data !== 8'(8'h3A + i)) begin
                failures++; $display("FAIL wrap_tail i=%0d got=%h exp=%h", i, a_p_data, 8'(8'h3A + i)); end
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_full_read();
        logic [7:0] exp [5];
        exp[0] = 8'h22; exp[1] = 8'h23; exp[2] = 8'h24; exp[3] = 8'h25; exp[4] = 8'h99;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a_c_srdy = 1; a_c_data = 8'(8'h21 + i); a_p_drdy = 0;
        end
        @(negedge clk);
        a_c_srdy = 1; a_c_data = 8'h99; a_p_drdy = 1;
        #1;
        checks++; if (a_c_drdy !== 1'b0 || a_p_srdy !== 1'b1) begin
            failures++; $display("FAIL full_rd_same_cycle got drdy=%b srdy=%b exp 0/1", a_c_drdy, a_p_srdy); end
        @(negedge clk);
        a_p_drdy = 0;
        #1;
        checks++; if (a_usage !== 3'd4 || a_c_drdy !== 1'b1) begin
            failures++; $display("FAIL full_rd_next got usage=%0d drdy=%b exp 4/1", a_usage, a_c_drdy); end
        @(negedge clk);
        a_c_srdy = 0;
        #1;
        checks++; if (a_usage !== 3'd5) begin failures++; $display("FAIL full_rd_refill got=%0d exp=5", a_usage); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a_p_drdy = 1;
            #1;
            checks++; if (a_p_data !== exp[i]) begin failures++; $display("FAIL full_rd_order i=%0d got=%h exp=%h", i, a_p_data, exp[i]); end
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_clear();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_c_srdy = 1; a_c_data = 8'(8'h41 + i); a_p_drdy = 0;
        end
        @(negedge clk);
        a_clear = 1; a_c_srdy = 1; a_c_data = 8'hEE; a_p_drdy = 1;
        #1;
        checks++; if (a_c_drdy !== 1'b0 || a_p_srdy !== 1'b0) begin
            failures++; $display("FAIL clear_gate got drdy=%b srdy=%b exp 0/0", a_c_drdy, a_p_srdy); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (a_usage !== 3'd0 || a_p_srdy !== 1'b0 || a_ae !== 1'b1) begin
            failures++; $display("FAIL clear_after got usage=%0d srdy=%b ae=%b exp 0/0/1", a_usage, a_p_srdy, a_ae); end
        @(negedge clk);
        a_c_srdy = 1; a_c_data = 8'h77;
        @(negedge clk);
        a_c_srdy = 0; a_p_drdy = 1;
        #1;
        checks++; if (a_p_srdy !== 1'b1 || a_p_data !== 8'h77) begin
            failures++; $display("FAIL clear_no_stale got srdy=%b data=%h exp 1/77", a_p_srdy, a_p_data); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_outreg_latency();
        @(negedge clk);
        b_c_srdy = 1; b_c_data = 8'hA5;
        @(negedge clk);
        b_c_srdy = 0;
        #1;
        checks++; if (b_p_srdy !== 1'b0 || b_usage !== 3'd1) begin
            failures++; $display("FAIL outreg_n1 got srdy=%b usage=%0d exp 0/1", b_p_srdy, b_usage); end
        @(negedge clk);
        b_p_drdy = 1;
        #1;
        checks++; if (b_p_srdy !== 1'b1 || b_p_data !== 8'hA5) begin
            failures++; $display("FAIL outreg_n2 got srdy=%b data=%h exp 1/a5", b_p_srdy, b_p_data); end
        @(negedge clk);
        b_p_drdy = 0;
        #1;
        checks++; if (b_usage !== 3'd0 || b_p_srdy !== 1'b0) begin
            failures++; $display("FAIL outreg_drained got usage=%0d srdy=%b exp 0/0", b_usage, b_p_srdy); end
    endtask

    task automatic test_stream();
        int sent = 0, rcv = 0, first = -1, last = -1;
        for (int cyc = 0; cyc < 130 && rcv < 100; cyc++) begin
            @(negedge clk);
            b_c_srdy = (sent < 100); b_c_data = 8'(sent); b_p_drdy = 1;
            #1;
            if (b_p_srdy) begin
                checks++; if (b_p_data !== 8'(rcv)) begin failures++; $display("FAIL stream_data n=%0d got=%h exp=%h", rcv, b_p_data, 8'(rcv)); end
                if (first < 0) first = cyc;
                last = cyc;
                rcv++;
            end
            if (b_c_srdy && b_c_drdy) sent++;
        end
        checks++; if (rcv !== 100) begin failures++; $display("FAIL stream_count got=%0d exp=100", rcv); end
        checks++; if (last - first + 1 !== 100) begin failures++; $display("FAIL stream_rate got span=%0d exp=100", last - first + 1); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            a_clear = ($urandom_range(0, 19) == 0); a_c_srdy = $urandom_range(0, 1) == 1;
            a_p_drdy = $urandom_range(0, 2) != 0; a_c_data = 8'($urandom);
            b_clear = ($urandom_range(0, 19) == 0); b_c_srdy = $urandom_range(0, 2) != 0;
            b_p_drdy = $urandom_range(0, 1) == 1; b_c_data = 8'($urandom);
            #1;
            checks++; if (a_c_drdy !== ((qa.size() < 5) && !a_clear) || a_p_srdy !== ((qa.size() > 0) && !a_clear)) begin
                failures++; $display("FAIL rnd_a_hs cyc=%0d got drdy=%b srdy=%b size=%0d", cyc, a_c_drdy, a_p_srdy, qa.size()); end
            checks++; if (a_usage !== 3'(qa.size()) || a_af !== (qa.size() >= 3) || a_ae !== (qa.size() <= 1)) begin
                failures++; $display("FAIL rnd_a_status cyc=%0d got usage=%0d af=%b ae=%b exp usage=%0d", cyc, a_usage, a_af, a_ae, qa.size()); end
            if (a_p_srdy && qa.size() > 0) begin
                checks++; if (a_p_data !== qa[0]) begin failures++; $display("FAIL rnd_a_data cyc=%0d got=%h exp=%h", cyc, a_p_data, qa[0]); end
            end
            checks++; if (b_c_drdy !== ((qb.size() < 4) && !b_clear) || b_p_srdy !== ((preb != 0) && !b_clear)) begin
                failures++; $display("FAIL rnd_b_hs cyc=%0d got drdy=%b srdy=%b size=%0d pre=%0d", cyc, b_c_drdy, b_p_srdy, qb.size(), preb); end
            checks++; if (b_usage !== 3'(qb.size()) || b_af !== (qb.size() >= 2) || b_ae !== (qb.size() <= 1)) begin
                failures++; $display("FAIL rnd_b_status cyc=%0d got usage=%0d af=%b ae=%b exp usage=%0d", cyc, b_usage, b_af, b_ae, qb.size()); end
            if (b_p_srdy && qb.size() > 0) begin
                checks++; if (b_p_data !== qb[0]) begin failures++; $display("FAIL rnd_b_data cyc=%0d got=%h exp=%h", cyc, b_p_data, qb[0]); end
            end
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            a_c_srdy = 1; a_c_data = 8'(8'h60 + i);
            b_c_srdy = 1; b_c_data = 8'(8'h70 + i);
        end
        @(negedge clk);
        idle();
        #1;
        checks++; if (a_usage !== 3'd2) begin failures++; $display("FAIL arst_pre got usage=%0d exp=2", a_usage); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (a_p_srdy !== 1'b0 || a_usage !== 3'd0 || a_c_drdy !== 1'b0) begin
            failures++; $display("FAIL arst_a got srdy=%b usage=%0d drdy=%b exp 0/0/0", a_p_srdy, a_usage, a_c_drdy); end
        checks++; if (b_p_srdy !== 1'b0 || b_usage !== 3'd0) begin
            failures++; $display("FAIL arst_b got srdy=%b usage=%0d exp 0/0", b_p_srdy, b_usage); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full_read();
        test_clear();
        test_outreg_latency();
        test_stream();
        test_random();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
